// File: rtl/sdram_arbiter_if.sv
// Client/controller bundle of the SDRAM arbiter: per-port request buses plus
// the single shared controller user-side bus.
interface sdram_arbiter_if #(
  parameter int NPORTS    = 4,
  parameter int ADDR_BITS = 24,
  parameter int DATA_BITS = 16
) ();
  logic [NPORTS-1:0]           req_r;
  logic [NPORTS-1:0]           req_w;
  logic [NPORTS*ADDR_BITS-1:0] req_addr;
  logic [NPORTS*DATA_BITS-1:0] req_dw;
  logic [NPORTS-1:0]           ack;
  logic [NPORTS-1:0]           rvalid;
  logic [DATA_BITS-1:0]        rdata;
  logic [ADDR_BITS-1:0]        m_addr;
  logic                        m_r;
  logic                        m_w;
  logic [DATA_BITS-1:0]        m_dw;
  logic [DATA_BITS-1:0]        m_dr;
  logic                        m_busy;

  modport slave (
    input  req_r, req_w, req_addr, req_dw, m_dr, m_busy,
    output ack, rvalid, rdata, m_addr, m_r, m_w, m_dw
  );

  modport master (
    output req_r, req_w, req_addr, req_dw, m_dr, m_busy,
    input  ack, rvalid, rdata, m_addr, m_r, m_w, m_dw
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller between NPORTS clients;
// one transaction in flight, read data routed back to the granted port.
module sdram_arbiter #(
  parameter int NPORTS    = 4,
  parameter int ADDR_BITS = 24,
  parameter int DATA_BITS = 16
) (
  input logic          clk,
  input logic          rst,
  sdram_arbiter_if.slave bus
);
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         grant_q, grant_d;
  logic                  seen_q, seen_d;
  logic                  is_read_q, is_read_d;
  logic [NPORTS-1:0]     ack_q, ack_d;
  logic [NPORTS-1:0]     rvalid_q, rvalid_d;
  logic [DATA_BITS-1:0]  rdata_q, rdata_d;
  logic [ADDR_BITS-1:0]  m_addr_q, m_addr_d;
  logic [DATA_BITS-1:0]  m_dw_q, m_dw_d;
  logic                  m_r_q, m_r_d;
  logic                  m_w_q, m_w_d;

  logic [NPORTS-1:0]     req_any;
  logic [ADDR_BITS-1:0]  addr_arr [NPORTS];
  logic [DATA_BITS-1:0]  dw_arr   [NPORTS];
  logic                  found;
  logic [PW-1:0]         gsel;
  logic [PW-1:0]         idx;

  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
      assign req_any[gi]  = bus.req_r[gi] | bus.req_w[gi];
      assign addr_arr[gi] = bus.req_addr[gi*ADDR_BITS +: ADDR_BITS];
      assign dw_arr[gi]   = bus.req_dw[gi*DATA_BITS +: DATA_BITS];
    end
  endgenerate

  // First requesting port at or after ptr, wrapping modulo NPORTS.
  always_comb begin
    found = 1'b0;
    gsel  = '0;
    idx   = '0;
    for (int k = 0; k < NPORTS; k++) begin
      idx = PW'((int'(ptr_q) + k) % NPORTS);
      if (!found && req_any[idx]) begin
        found = 1'b1;
        gsel  = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    seen_d    = seen_q;
    is_read_d = is_read_q;
    ack_d     = '0;
    rvalid_d  = '0;
    rdata_d   = rdata_q;
    m_addr_d  = m_addr_q;
    m_dw_d    = m_dw_q;
    m_r_d     = 1'b0;
    m_w_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.m_busy && found) begin
          state_d     = ISSUE;
          grant_d     = gsel;
          m_addr_d    = addr_arr[gsel];
          m_dw_d      = dw_arr[gsel];
          // A write wins when both are requested; the ack retires both.
          m_w_d       = bus.req_w[gsel];
          m_r_d       = !bus.req_w[gsel];
          is_read_d   = !bus.req_w[gsel];
          ack_d[gsel] = 1'b1;
          ptr_d       = (gsel == PW'(NPORTS - 1)) ? '0 : gsel + 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        seen_d  = 1'b0;
      end
      WAIT: begin
        if (bus.m_busy) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          state_d = DONE;
          if (is_read_q) begin
            rdata_d           = bus.m_dr;
            rvalid_d[grant_q] = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      seen_q    <= 1'b0;
      is_read_q <= 1'b0;
      ack_q     <= '0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
      m_addr_q  <= '0;
      m_dw_q    <= '0;
      m_r_q     <= 1'b0;
      m_w_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      seen_q    <= seen_d;
      is_read_q <= is_read_d;
      ack_q     <= ack_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      m_addr_q  <= m_addr_d;
      m_dw_q    <= m_dw_d;
      m_r_q     <= m_r_d;
      m_w_q     <= m_w_d;
    end
  end

  assign bus.ack    = ack_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.m_addr = m_addr_q;
  assign bus.m_dw   = m_dw_q;
  assign bus.m_r    = m_r_q;
  assign bus.m_w    = m_w_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: behavioural SDRAM controller, self-clearing clients
// and a read-data scoreboard, all stepped on the falling clock edge.
module tb_sdram_arbiter;
  localparam int NP = 4;
  localparam int AB = 24;
  localparam int DB = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_arbiter_if #(.NPORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  sdram_arbiter #(.NPORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          port;
    logic [15:0] data;
  } rd_exp_t;

  int          errors = 0;
  int          checks = 0;
  int          viol = 0;
  int          rv_count = 0;
  rd_exp_t     exp_q[$];
  int          ack_log[$];
  logic        ack_op_w[$];
  logic [3:0]  cont = '0;
  int          mcnt = 0;
  int          busy_len = 5;
  logic        mop_w = 1'b0;
  logic [23:0] maddr = '0;
  logic [15:0] mem [int];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(logic [23:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic drive(int p, bit r, bit w, logic [23:0] a, logic [15:0] d);
    bus.req_addr[p*AB +: AB] = a;
    bus.req_dw[p*DB +: DB]   = d;
    bus.req_r[p]             = r;
    bus.req_w[p]             = w;
  endtask

  // One clock: monitor outputs, retire acked requests, advance the controller.
  task automatic step();
    rd_exp_t e;
    @(negedge clk);
    if (bus.ack != '0) begin
      if (!$onehot(bus.ack)) viol++;
      for (int p = 0; p < NP; p++) begin
        if (bus.ack[p]) begin
          ack_log.push_back(p);
          ack_op_w.push_back(bus.m_w);
          $display("t=%0t ack port=%0d %s addr=%h dw=%h", $time, p,
                   bus.m_w ? "write" : "read", bus.m_addr, bus.m_dw);
        end
      end
    end
    if ((bus.m_r || bus.m_w) && bus.m_busy) viol++;
    if ((bus.m_r || bus.m_w) && bus.ack == '0) viol++;
    if (bus.m_r && bus.m_w) viol++;
    if (bus.rvalid != '0) begin
      rv_count++;
      if (exp_q.size() == 0) begin
        check("rvalid_unexpected", 32'(bus.rvalid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rvalid_port", 32'(bus.rvalid), 32'd1 << e.port);
        check("rdata", 32'(bus.rdata), 32'(e.data));
        $display("t=%0t rvalid port=%0d rdata=%h", $time, e.port, bus.rdata);
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (bus.ack[p] && !cont[p]) begin
        bus.req_r[p] = 1'b0;
        bus.req_w[p] = 1'b0;
      end
    end
    if (bus.m_r || bus.m_w) begin
      bus.m_busy = 1'b1;
      mcnt       = busy_len;
      mop_w      = bus.m_w;
      maddr      = bus.m_addr;
      if (bus.m_w) mem[int'(bus.m_addr)] = bus.m_dw;
      bus.m_dr   = 16'($urandom);
    end else if (bus.m_busy) begin
      mcnt--;
      if (mcnt == 0) begin
        bus.m_busy = 1'b0;
        bus.m_dr   = mop_w ? 16'($urandom) : mem_rd(maddr);
      end else begin
        bus.m_dr = 16'($urandom);
      end
    end else begin
      bus.m_dr = 16'($urandom);
    end
  endtask

  task automatic wait_quiet(int budget, string tag);
    int q;
    bit done;
    q    = 0;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      if (bus.req_r == '0 && bus.req_w == '0 && !bus.m_busy && exp_q.size() == 0) q++;
      else q = 0;
      if (q >= 4) done = 1'b1;
    end
    if (!done) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int r0;
    bit hit;
    rst          = 1'b1;
    bus.req_r    = '0;
    bus.req_w    = '0;
    bus.req_addr = '0;
    bus.req_dw   = '0;
    bus.m_busy   = 1'b0;
    bus.m_dr     = '0;
    repeat (3) step();
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_m_r", 32'(bus.m_r), 32'd0);
    check("rst_m_w", 32'(bus.m_w), 32'd0);
    check("rst_m_addr", 32'(bus.m_addr), 32'd0);
    check("rst_m_dw", 32'(bus.m_dw), 32'd0);
    rst = 1'b0;
    step();

    // All ports writing continuously from ptr=0.
    cont = 4'hF;
    for (int p = 0; p < NP; p++) drive(p, 1'b0, 1'b1, 24'h1000 + 24'(p), 16'h0100 + 16'(p));
    ack_log.delete();
    ack_op_w.delete();
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      step();
      if (ack_log.size() >= 8) hit = 1'b1;
    end
    if (!hit) check("t3_timeout", 32'd1, 32'd0);
    cont = 4'h0;
    wait_quiet(200, "t3");
    check("t3_ack_count", 32'(ack_log.size()), 32'd12);
    for (int i = 0; i < ack_log.size(); i++) check("t3_order", 32'(ack_log[i]), 32'(i % 4));

    // Single read on port 2.
    mem[int'(24'h123456)] = 16'hBEEF;
    ack_log.delete();
    r0 = rv_count;
    drive(2, 1'b1, 1'b0, 24'h123456, 16'h0);
    exp_q.push_back('{port: 2, data: 16'hBEEF});
    step();
    check("t1_ack", 32'(bus.ack), 32'h4);
    check("t1_m_r", 32'(bus.m_r), 32'd1);
    check("t1_m_w", 32'(bus.m_w), 32'd0);
    check("t1_m_addr", 32'(bus.m_addr), 32'h123456);
    step();
    check("t1_m_r_drop", 32'(bus.m_r), 32'd0);
    check("t1_ack_drop", 32'(bus.ack), 32'd0);
    check("t1_addr_hold", 32'(bus.m_addr), 32'h123456);
    wait_quiet(100, "t1");
    check("t1_rvalid_count", 32'(rv_count - r0), 32'd1);
    check("t1_ack_count", 32'(ack_log.size()), 32'd1);

    // Single write on port 0.
    ack_log.delete();
    r0 = rv_count;
    drive(0, 1'b0, 1'b1, 24'h000010, 16'hA5A5);
    step();
    check("t2_ack", 32'(bus.ack), 32'h1);
    check("t2_m_w", 32'(bus.m_w), 32'd1);
    check("t2_m_r", 32'(bus.m_r), 32'd0);
    check("t2_m_dw", 32'(bus.m_dw), 32'hA5A5);
    check("t2_m_addr", 32'(bus.m_addr), 32'h10);
    step();
    check("t2_m_w_drop", 32'(bus.m_w), 32'd0);
    check("t2_dw_hold", 32'(bus.m_dw), 32'hA5A5);
    wait_quiet(100, "t2");
    check("t2_no_rvalid", 32'(rv_count - r0), 32'd0);
    check("t2_mem", 32'(mem_rd(24'h10)), 32'hA5A5);

    // Port 1 alone moves ptr to 2; then ports 0 and 3 together.
    drive(1, 1'b0, 1'b1, 24'h000020, 16'h1111);
    wait_quiet(100, "t4a");
    ack_log.delete();
    drive(0, 1'b0, 1'b1, 24'h000030, 16'h2222);
    drive(3, 1'b0, 1'b1, 24'h000031, 16'h3333);
    wait_quiet(200, "t4");
    check("t4_ack_count", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() >= 2) begin
      check("t4_first", 32'(ack_log[0]), 32'd3);
      check("t4_second", 32'(ack_log[1]), 32'd0);
    end

    // Port 1 read+write together, then read alone.
    ack_log.delete();
    ack_op_w.delete();
    r0 = rv_count;
    drive(1, 1'b1, 1'b1, 24'h000200, 16'h1234);
    wait_quiet(100, "t5a");
    check("t5_wr_acks", 32'(ack_log.size()), 32'd1);
    if (ack_op_w.size() >= 1) check("t5_wr_op", 32'(ack_op_w[0]), 32'd1);
    check("t5_wr_no_rvalid", 32'(rv_count - r0), 32'd0);
    check("t5_mem", 32'(mem_rd(24'h200)), 32'h1234);
    drive(1, 1'b1, 1'b0, 24'h000200, 16'h0);
    exp_q.push_back('{port: 1, data: 16'h1234});
    wait_quiet(100, "t5b");
    check("t5_rd_acks", 32'(ack_log.size()), 32'd2);
    if (ack_op_w.size() >= 2) check("t5_rd_op", 32'(ack_op_w[1]), 32'd0);
    check("t5_rd_rvalid", 32'(rv_count - r0), 32'd1);

    // Reset during WAIT with the controller busy.
    busy_len = 10;
    drive(0, 1'b0, 1'b1, 24'h000300, 16'h7777);
    repeat (3) step();
    drive(1, 1'b1, 1'b0, 24'h000040, 16'h0);
    exp_q.push_back('{port: 1, data: 16'h5A1A});
    ack_log.delete();
    ack_op_w.delete();
    r0 = rv_count;
    rst = 1'b1;
    step();
    check("t6_ack", 32'(bus.ack), 32'd0);
    check("t6_rvalid", 32'(bus.rvalid), 32'd0);
    check("t6_rdata", 32'(bus.rdata), 32'd0);
    check("t6_m_r", 32'(bus.m_r), 32'd0);
    check("t6_m_w", 32'(bus.m_w), 32'd0);
    check("t6_m_addr", 32'(bus.m_addr), 32'd0);
    check("t6_m_dw", 32'(bus.m_dw), 32'd0);
    rst = 1'b0;
    busy_len = 5;
    for (int i = 0; i < 50 && bus.m_busy; i++) step();
    check("t6_no_issue_busy", 32'(ack_log.size()), 32'd0);
    wait_quiet(100, "t6");
    check("t6_acks", 32'(ack_log.size()), 32'd1);
    if (ack_log.size() >= 1) check("t6_port", 32'(ack_log[0]), 32'd1);
    if (ack_op_w.size() >= 1) check("t6_op", 32'(ack_op_w[0]), 32'd0);
    check("t6_rvalid_count", 32'(rv_count - r0), 32'd1);

    check("protocol_violations", 32'(viol), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
